muldiv_unit: RTL

- Iterative multiply/divide unit with architectural HI/LO registers, parametrised in datapath width.
- Decodes the MIPS SPECIAL funct codes mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Sits beside the ALU in the execute stage and holds busy high while an operation runs; the core stalls HI/LO consumers on busy.
- Extends the combinational funct decoding used for ALU control into a multi-cycle, stateful engine.

---
 rtl/muldiv_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide engine with architectural HI/LO.
// Multiply is shift-add and divide is restoring; each retires one bit per
// RUN cycle. A final FIX cycle applies sign correction and writes HI/LO.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [DW-1:0]    ONE_DW   = DW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    acc_q;
    logic [WIDTH-1:0] opd_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             div0_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    // Decode/operand-preparation signals
    logic             is_mul_c;
    logic             is_div_c;
    logic             signed_op_c;
    logic             sign_a_c;
    logic             sign_b_c;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;

    // Iteration datapath signals
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_rem_c;
    logic [WIDTH:0]   div_diff_c;
    logic             div_ge_c;
    logic [DW-1:0]    acc_d;

    // Sign-correction signals
    logic [DW-1:0]    prod_neg_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    // Funct decode and operand magnitudes for the accepting cycle
    always_comb begin
        is_mul_c    = 1'b0;
        is_div_c    = 1'b0;
        signed_op_c = 1'b0;
        unique case (funct)
            F_MULT:  begin is_mul_c = 1'b1; signed_op_c = 1'b1; end
            F_MULTU: begin is_mul_c = 1'b1; end
            F_DIV:   begin is_div_c = 1'b1; signed_op_c = 1'b1; end
            F_DIVU:  begin is_div_c = 1'b1; end
            default: ;
        endcase
        sign_a_c = signed_op_c & a[WIDTH-1];
        sign_b_c = signed_op_c & b[WIDTH-1];
        abs_a_c  = sign_a_c ? (~a + ONE_W) : a;
        abs_b_c  = sign_b_c ? (~b + ONE_W) : b;
    end

    // One shift-add or one restoring-divide step on the accumulator
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_rem_c  = acc_q[DW-1:WIDTH-1];
        div_diff_c = div_rem_c - {1'b0, opd_q};
        div_ge_c   = (div_rem_c >= {1'b0, opd_q});
        acc_d      = {mul_sum_c, acc_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (div_ge_c) begin
                acc_d = {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_rem_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction of the finished magnitude result
    always_comb begin
        prod_neg_c = ~acc_q + ONE_DW;
        quo_c      = acc_q[WIDTH-1:0];
        rem_c      = acc_q[DW-1:WIDTH];
        hi_d       = acc_q[DW-1:WIDTH];
        lo_d       = acc_q[WIDTH-1:0];
        if (is_div_q) begin
            // Division by zero leaves |a| as remainder; re-signing restores a
            hi_d = neg_rem_q ? (~rem_c + ONE_W) : rem_c;
            if (div0_q) begin
                lo_d = '1;
            end else begin
                lo_d = neg_res_q ? (~quo_c + ONE_W) : quo_c;
            end
        end else if (neg_res_q) begin
            hi_d = prod_neg_c[DW-1:WIDTH];
            lo_d = prod_neg_c[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul_c || is_div_c) begin
                            state_q   <= S_RUN;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            is_div_q  <= is_div_c;
                            neg_res_q <= sign_a_c ^ sign_b_c;
                            neg_rem_q <= is_div_c & sign_a_c;
                            div0_q    <= is_div_c & (b == '0);
                            if (is_div_c) begin
                                acc_q <= {{WIDTH{1'b0}}, abs_a_c};
                                opd_q <= abs_b_c;
                            end else begin
                                acc_q <= {{WIDTH{1'b0}}, abs_b_c};
                                opd_q <= abs_a_c;
                            end
                        end else begin
                            unique case (funct)
                                F_MTHI:         hi_q  <= a;
                                F_MTLO:         lo_q  <= a;
                                F_MFHI, F_MFLO: ;
                                default:        err_q <= 1'b1;
                            endcase
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign rdata = (funct == F_MFHI) ? hi_q : lo_q;

endmodule
